imem_loadable: RTL and testbench
================================

// Module: imem_loadable
// PURPOSE
//   Parametrised synchronous instruction memory with a sequential load port and a registered fetch port.
//   A boot/test loader streams a program into the array; the fetch stage then reads it with 1-cycle latency.
//   A valid/stall handshake on the fetch side lets the pipeline freeze the fetch output.
//   Sits between the program loader and the fetch/decode stage of the CPU datapath.
// PARAMETERS
//   DATA_W  32   instruction width in bits
//   ADDR_W  8    PC / address width in bits
//   DEPTH   256  number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
//   NOP     0    DATA_W-bit word returned for out-of-range fetches
// PORTS
//   clk          in   1          single clock; all logic on the rising edge
//   rst          in   1          synchronous, active-high reset
//   load_start   in   1          enter LOAD state and reset the write pointer
//   load_valid   in   1          load_data is valid this cycle
//   load_last    in   1          qualifies load_valid: this is the final word
//   load_data    in   DATA_W     word to write at the write pointer
//   run_start    in   1          IDLE -> RUN without loading; array contents are kept
//   fetch_req    in   1          fetch request for fetch_pc
//   fetch_pc     in   ADDR_W     word address to fetch
//   fetch_stall  in   1          downstream stalled; hold the current fetch output
//   instr        out  DATA_W     fetched instruction
//   instr_valid  out  1          instr, addr_err valid
//   addr_err     out  1          fetch_pc >= DEPTH for this instr
//   loading      out  1          state == LOAD
//   ready        out  1          state == RUN
//   load_count   out  ADDR_W+1   words written since last load_start
// BEHAVIOUR
//   States: IDLE, LOAD, RUN. rst -> IDLE.
//   Reset values: instr=0, instr_valid=0, addr_err=0, load_count=0, wptr=0.
//   Reset does not clear the array; reset mid-load keeps already-written words.
//   IDLE:
//     load_start -> LOAD; wptr=0; load_count=0.
//     else run_start -> RUN.
//     fetch_req is ignored.
//   LOAD:
//     load_valid writes mem[wptr]=load_data, then wptr++ and load_count++.
//     Transition to RUN after the write if load_last=1 or wptr==DEPTH-1; that last write always completes.
//     load_start in LOAD restarts: wptr=0, load_count=0, and any same-cycle load_valid is dropped.
//     Fetches are ignored. instr_valid=0 throughout LOAD.
//   RUN:
//     accept = fetch_req & ~(instr_valid & fetch_stall).
//     On accept, the next cycle gives instr_valid=1:
//       fetch_pc < DEPTH: instr=mem[fetch_pc], addr_err=0.
//       else: instr=NOP, addr_err=1.
//     instr_valid & fetch_stall: instr, instr_valid and addr_err are held unchanged; fetch_req is ignored, so the requester must hold it.
//     No accept and no stall: instr_valid=0 next cycle; instr holds its last value.
//     load_start -> LOAD. It takes priority over a same-cycle fetch_req (the fetch is dropped), and instr_valid goes to 0 next cycle even if stalled.
//   Latency: exactly 1 cycle, request edge to instr_valid.
//     Back-to-back requests give one instr per cycle.
//   Arithmetic: wptr and PC compare use ADDR_W+1 bits, so DEPTH == 2**ADDR_W never wraps.
//     load_count saturates at DEPTH.
// TESTING
//   1. rst; load_start; stream 6 words (last with load_last) = 32'h1002000A, 32'h1380000F, 32'h2C8AF000, 32'h3A640005, 32'h12800002, 32'h4F32A000 -> loading=1 during stream; load_count=6; ready=1 the cycle after the last word.
//   2. RUN: fetch_req with pc=0..5 back-to-back -> instr_valid=1 from cycle 1; instr matches words in order, one per cycle.
//   3. Hold fetch_req, pc=2; assert fetch_stall for 3 cycles -> instr=32'h2C8AF000 held; pc=3 is accepted only after fetch_stall drops.
//   4. DEPTH=16, fetch pc=8'd20 -> instr=NOP, addr_err=1, instr_valid=1. Then pc=4 -> addr_err=0.
//   5. Stream DEPTH words with no load_last -> auto RUN after word DEPTH-1; load_count=DEPTH; a further load_valid writes nothing.
//   6. rst after 3 words of a load; then run_start and fetch pc=1 -> state IDLE after rst; instr = the word written before reset.

Source files
------------

// File: rtl/imem_loadable.sv
// Loadable instruction memory: a sequential load port streams a program in,
// then a registered fetch port reads it with one cycle of latency and stall hold.
module imem_loadable #(
    parameter int                DATA_W = 32,
    parameter int                ADDR_W = 8,
    parameter int                DEPTH  = 256,
    parameter logic [DATA_W-1:0] NOP    = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_last,
    input  logic [DATA_W-1:0] load_data,
    input  logic              run_start,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              fetch_stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_err,
    output logic              loading,
    output logic              ready,
    output logic [ADDR_W:0]   load_count
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W:0]   wptr_r;
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic              write_s;
    logic              accept_s;
    logic              in_range_s;

    // load_start always wins: it drops a same-cycle write or fetch
    assign write_s    = (state_r == ST_LOAD) & load_valid & ~load_start;
    assign accept_s   = (state_r == ST_RUN) & fetch_req & ~(instr_valid & fetch_stall) & ~load_start;
    assign in_range_s = ({1'b0, fetch_pc} < DEPTH_C);
    assign loading    = (state_r == ST_LOAD);
    assign ready      = (state_r == ST_RUN);

    // Array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (write_s && !rst) begin
            mem[wptr_r[IDX_W-1:0]] <= load_data;
        end
    end

    // Control state, write pointer, load counter and registered fetch output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            wptr_r      <= {(ADDR_W + 1){1'b0}};
            load_count  <= {(ADDR_W + 1){1'b0}};
            instr       <= {DATA_W{1'b0}};
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    instr_valid <= 1'b0;
                    if (load_start) begin
                        state_r    <= ST_LOAD;
                        wptr_r     <= {(ADDR_W + 1){1'b0}};
                        load_count <= {(ADDR_W + 1){1'b0}};
                    end else if (run_start) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    instr_valid <= 1'b0;
                    if (load_start) begin
                        wptr_r     <= {(ADDR_W + 1){1'b0}};
                        load_count <= {(ADDR_W + 1){1'b0}};
                    end else if (load_valid) begin
                        wptr_r <= wptr_r + {{ADDR_W{1'b0}}, 1'b1};
                        if (load_count != DEPTH_C) begin
                            load_count <= load_count + {{ADDR_W{1'b0}}, 1'b1};
                        end else begin
                            load_count <= load_count;
                        end
                        // The final array slot ends the load even without load_last
                        if (load_last || (wptr_r == LAST_C)) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_RUN: begin
                    if (load_start) begin
                        state_r     <= ST_LOAD;
                        wptr_r      <= {(ADDR_W + 1){1'b0}};
                        load_count  <= {(ADDR_W + 1){1'b0}};
                        instr_valid <= 1'b0;
                    end else if (accept_s) begin
                        instr_valid <= 1'b1;
                        if (in_range_s) begin
                            instr    <= mem[fetch_pc[IDX_W-1:0]];
                            addr_err <= 1'b0;
                        end else begin
                            instr    <= NOP;
                            addr_err <= 1'b1;
                        end
                    end else if (instr_valid && fetch_stall) begin
                        instr_valid <= instr_valid;
                        instr       <= instr;
                        addr_err    <= addr_err;
                    end else begin
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable with a fetch scoreboard queue; DEPTH=16 and a
// non-zero NOP so out-of-range fetches are distinguishable from reset data.
module tb_imem_loadable;

    localparam int          DW   = 32;
    localparam int          AW   = 8;
    localparam int          DEP  = 16;
    localparam logic [31:0] NOPW = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] ins;
        logic        err;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          load_start;
    logic          load_valid;
    logic          load_last;
    logic [DW-1:0] load_data;
    logic          run_start;
    logic          fetch_req;
    logic [AW-1:0] fetch_pc;
    logic          fetch_stall;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          addr_err;
    logic          loading;
    logic          ready;
    logic [AW:0]   load_count;

    int          tests;
    int          fails;
    logic [31:0] ref_mem [0:DEP-1];
    logic [31:0] prog [0:5] = '{32'h1002000A, 32'h1380000F, 32'h2C8AF000,
                                32'h3A640005, 32'h12800002, 32'h4F32A000};
    exp_t        q[$];
    bit          in_run;
    bit          m_valid;
    logic [31:0] m_instr;
    logic        m_err;

    imem_loadable #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NOP(NOPW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_last(load_last), .load_data(load_data), .run_start(run_start),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
        .instr(instr), .instr_valid(instr_valid), .addr_err(addr_err),
        .loading(loading), .ready(ready), .load_count(load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: push the expected fetch result if accepted, then pop and compare after the edge
    task automatic cyc();
        bit   acc;
        bit   hold;
        exp_t e;
        acc  = in_run && fetch_req && !(m_valid && fetch_stall) && !load_start;
        hold = in_run && !load_start && !acc && m_valid && fetch_stall;
        if (acc) begin
            e.ins = (int'(fetch_pc) < DEP) ? ref_mem[fetch_pc[3:0]] : NOPW;
            e.err = (int'(fetch_pc) >= DEP);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (acc) begin
            e       = q.pop_front();
            m_valid = 1'b1;
            m_instr = e.ins;
            m_err   = e.err;
        end else if (!hold) begin
            m_valid = 1'b0;
        end
        chk("instr_valid", {63'd0, instr_valid}, {63'd0, m_valid});
        if (m_valid) begin
            chk("instr", {32'd0, instr}, {32'd0, m_instr});
            chk("addr_err", {63'd0, addr_err}, {63'd0, m_err});
        end
    endtask

    initial begin
        tests = 0; fails = 0; in_run = 1'b0; m_valid = 1'b0; m_instr = 32'd0; m_err = 1'b0;
        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = 32'd0; run_start = 1'b0; fetch_req = 1'b0; fetch_pc = 8'd0; fetch_stall = 1'b0;
        for (int i = 0; i < DEP; i++) ref_mem[i] = 32'd0;

        // reset state
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_addr_err", {63'd0, addr_err}, 64'd0);
        chk("rst_load_count", {55'd0, load_count}, 64'd0);
        chk("rst_loading", {63'd0, loading}, 64'd0);
        chk("rst_ready", {63'd0, ready}, 64'd0);

        // test 1: load six words
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        chk("t1_loading", {63'd0, loading}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = (i == 5);
            cyc();
            ref_mem[i] = prog[i];
            chk("t1_load_count", {55'd0, load_count}, 64'(i + 1));
            chk("t1_loading_s", {63'd0, loading}, (i < 5) ? 64'd1 : 64'd0);
            chk("t1_ready", {63'd0, ready}, (i < 5) ? 64'd0 : 64'd1);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        in_run     = 1'b1;

        // test 2: back-to-back fetches
        fetch_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fetch_pc = 8'(i);
            cyc();
        end

        // test 3: stall holds pc=2 output; pc=3 accepted after release
        fetch_pc = 8'd2;
        cyc();
        fetch_stall = 1'b1;
        fetch_pc    = 8'd3;
        repeat (3) cyc();
        chk("t3_held", {32'd0, instr}, 64'h2C8AF000);
        fetch_stall = 1'b0;
        cyc();
        fetch_req = 1'b0;
        cyc();
        chk("t3_instr_keep", {32'd0, instr}, 64'h3A640005);

        // test 4: out-of-range then in-range fetch
        fetch_req = 1'b1;
        fetch_pc  = 8'd20;
        cyc();
        fetch_pc = 8'd4;
        cyc();

        // load_start beats a stalled valid output and a pending fetch
        fetch_pc = 8'd1;
        cyc();
        fetch_stall = 1'b1;
        load_start  = 1'b1;
        cyc();
        in_run = 1'b0;
        load_start = 1'b0; fetch_stall = 1'b0; fetch_req = 1'b0;
        chk("prio_loading", {63'd0, loading}, 64'd1);
        chk("prio_load_count", {55'd0, load_count}, 64'd0);

        // test 5: fill all DEPTH words without load_last
        for (int i = 0; i < DEP; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hA000_0000 + 32'(i);
            cyc();
            ref_mem[i] = 32'hA000_0000 + 32'(i);
        end
        chk("t5_ready", {63'd0, ready}, 64'd1);
        chk("t5_load_count", {55'd0, load_count}, 64'(DEP));
        in_run    = 1'b1;
        load_data = 32'hDEAD_BEEF;
        cyc();
        load_valid = 1'b0;
        chk("t5_count_sat", {55'd0, load_count}, 64'(DEP));
        fetch_req = 1'b1;
        fetch_pc  = 8'd0;
        cyc();
        fetch_pc = 8'd15;
        cyc();
        fetch_req = 1'b0;
        cyc();

        // test 6: reset in the middle of a load keeps written words
        load_start = 1'b1;
        cyc();
        in_run = 1'b0;
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h5555_0000 + 32'(i);
            cyc();
            ref_mem[i] = 32'h5555_0000 + 32'(i);
        end
        load_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_loading", {63'd0, loading}, 64'd0);
        chk("t6_ready", {63'd0, ready}, 64'd0);
        chk("t6_load_count", {55'd0, load_count}, 64'd0);
        chk("t6_instr", {32'd0, instr}, 64'd0);
        run_start = 1'b1;
        cyc();
        run_start = 1'b0;
        chk("t6_run", {63'd0, ready}, 64'd1);
        in_run    = 1'b1;
        fetch_req = 1'b1;
        fetch_pc  = 8'd1;
        cyc();
        fetch_pc = 8'd3;
        cyc();
        fetch_req = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
